// File: rtl/loader_pkg.sv
// loader_pkg: shared states, frame field widths and default header for the program loader.
package loader_pkg;

    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int COUNT_W = 16;

    localparam logic [BYTE_W-1:0] HEADER_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_e;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts four big-endian bytes into one instruction word.
// word_o already includes byte_i so the caller can latch the complete word on the 4th byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [1:0]        idx_q, idx_d;

    assign word_o = {shift_q[WORD_W-BYTE_W-1:0], byte_i};
    assign full_o = &idx_q;

    always_comb begin
        shift_d = clr_i ? '0 : en_i ? word_o : shift_q;
        idx_d   = clr_i ? '0 : en_i ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// program_loader: decodes a framed serial image into program memory writes
// and releases the processor only once the checksum has matched.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned       MEMORY_DEPTH = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDRESS = 32'h0040_0000,
    parameter logic [ADDR_W-1:0] PC_INCREMENT = 32'd4,
    parameter logic [BYTE_W-1:0] HEADER_BYTE  = HEADER_BYTE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [BYTE_W-1:0]  rx_data,
    output logic               rx_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    output logic               cpu_run,
    output logic               load_done,
    output logic               load_error,
    output logic [COUNT_W-1:0] words_loaded
);

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   xor_q, xor_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [COUNT_W-1:0]  wl_q, wl_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                run_q, done_q, err_q;
    logic                xfer, asm_clr, asm_en, asm_full;
    logic [WORD_W-1:0]   asm_word;
    logic [COUNT_W-1:0]  len;

    assign rx_ready     = state_q != S_WRITE;
    assign xfer         = rx_valid && rx_ready;
    assign len          = {cnt_q[COUNT_W-1:BYTE_W], rx_data};
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_run      = run_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = wl_q;

    word_assembler u_asm (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (asm_clr),
        .en_i   (asm_en),
        .byte_i (rx_data),
        .word_o (asm_word),
        .full_o (asm_full)
    );

    always_comb begin
        state_d = state_q;
        xor_d   = xor_q;
        cnt_d   = cnt_q;
        wl_d    = wl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        asm_clr = 1'b0;
        asm_en  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (xfer && rx_data == HEADER_BYTE) begin
                    state_d = S_LEN_HI;
                    xor_d   = '0;
                    wl_d    = '0;
                    addr_d  = BASE_ADDRESS;
                    asm_clr = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    cnt_d[COUNT_W-1:BYTE_W] = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    cnt_d   = len;
                    xor_d   = xor_q ^ rx_data;
                    state_d = 32'(len) > MEMORY_DEPTH ? S_ERROR :
                              len == '0               ? S_CHECK : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    xor_d  = xor_q ^ rx_data;
                    asm_en = 1'b1;
                    if (asm_full) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        wdata_d = asm_word;
                    end
                end
            end
            S_WRITE: begin
                wl_d    = wl_q + 16'd1;
                addr_d  = addr_q + PC_INCREMENT;
                state_d = wl_q + 16'd1 == cnt_q ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (xfer)
                    state_d = rx_data == xor_q ? S_DONE : S_ERROR;
            end
        endcase
    end

    // Status flags follow the next state so they rise on the same edge that accepts the deciding byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            xor_q   <= '0;
            cnt_q   <= '0;
            wl_q    <= '0;
            addr_q  <= BASE_ADDRESS;
            wdata_q <= '0;
            we_q    <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xor_q   <= xor_d;
            cnt_q   <= cnt_d;
            wl_q    <= wl_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            run_q   <= state_d == S_DONE;
            done_q  <= state_d == S_DONE;
            err_q   <= state_d == S_ERROR;
        end
    end

endmodule
